// File: rtl/bcd_scan_counter_pkg.sv
// bcd_pkg: BCD nibble type, decade limit and decoder bus-order helper.
// Rev 1.0
`default_nettype none

package bcd_pkg;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BCD_MAX = 4'd9;

  // The 7-segment decoder expects weight 8 on bit 0 and weight 1 on bit 3.
  function automatic logic [3:0] bitrev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_scan_counter_if.sv
// bcd_scan_counter_if: control, count and display signals of the scanning BCD counter.
// Rev 1.0
`default_nettype none

interface bcd_scan_counter_if #(
  parameter int NDIG = 4
);

  logic                tick;
  logic                up;
  logic                load;
  logic [4*NDIG-1:0]   load_val;
  logic [4*NDIG-1:0]   count;
  logic                wrap;
  logic [3:0]          disp_num;
  logic [NDIG-1:0]     disp_sel;

  modport master (
    output tick, up, load, load_val,
    input  count, wrap, disp_num, disp_sel
  );

  modport slave (
    input  tick, up, load, load_val,
    output count, wrap, disp_num, disp_sel
  );

endinterface

`default_nettype wire

// File: rtl/bcd_scan_counter_decade.sv
// bcd_decade: one combinational BCD decade step; carry_i doubles as borrow-in.
// Rev 1.0
`default_nettype none

module bcd_decade
  import bcd_pkg::*;
(
  input  bcd_t nib_i,
  input  logic inc_i,
  input  logic dec_i,
  input  logic carry_i,
  output bcd_t nib_o,
  output logic carry_o
);

  always_comb begin
    nib_o   = nib_i;
    carry_o = 1'b0;
    if (carry_i && inc_i) begin
      if (nib_i >= BCD_MAX) begin
        nib_o   = '0;
        carry_o = 1'b1;
      end else begin
        nib_o = nib_i + 4'd1;
      end
    end else if (carry_i && dec_i) begin
      if (nib_i == '0) begin
        nib_o   = BCD_MAX;
        carry_o = 1'b1;
      end else begin
        nib_o = nib_i - 4'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/bcd_scan_counter.sv
// bcd_scan_counter: NDIG-decade BCD up/down counter with multiplexed digit scanning.
// Rev 1.0
`default_nettype none

module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int NDIG     = 4,
  parameter int SCAN_DIV = 1024
) (
  input  logic                 clk,
  input  logic                 rst_n,
  bcd_scan_counter_if.slave    bus
);

  localparam int PREW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDXW = (NDIG > 1) ? $clog2(NDIG) : 1;

  bcd_t [NDIG-1:0]  count_q, count_d;
  logic             wrap_q, wrap_d;
  logic [PREW-1:0]  pre_q, pre_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [3:0]       disp_num_q, disp_num_d;
  logic [NDIG-1:0]  disp_sel_q, disp_sel_d;

  bcd_t [NDIG-1:0]  w_load_san;
  bcd_t [NDIG-1:0]  w_step;
  logic [NDIG:0]    w_carry;
  logic             w_inc;
  logic             w_dec;
  logic             w_pre_last;

  assign w_inc      = bus.tick &  bus.up & ~bus.load;
  assign w_dec      = bus.tick & ~bus.up & ~bus.load;
  assign w_carry[0] = 1'b1;

  // Decade 0 always steps; higher decades step only on carry/borrow ripple.
  for (genvar i = 0; i < NDIG; i++) begin : g_decade
    assign w_load_san[i] = (bus.load_val[4*i +: 4] > BCD_MAX) ? bcd_t'(0)
                                                              : bus.load_val[4*i +: 4];
    bcd_decade u_decade (
      .nib_i   (count_q[i]),
      .inc_i   (w_inc),
      .dec_i   (w_dec),
      .carry_i (w_carry[i]),
      .nib_o   (w_step[i]),
      .carry_o (w_carry[i+1])
    );
  end

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (bus.load) begin
      count_d = w_load_san;
    end else if (bus.tick) begin
      count_d = w_step;
      wrap_d  = w_carry[NDIG];
    end
  end

  assign w_pre_last = (pre_q == PREW'(SCAN_DIV - 1));

  always_comb begin
    pre_d = pre_q + PREW'(1);
    idx_d = idx_q;
    if (w_pre_last) begin
      pre_d = '0;
      idx_d = (idx_q == IDXW'(NDIG - 1)) ? '0 : idx_q + IDXW'(1);
    end
  end

  always_comb begin
    disp_num_d = bitrev4(count_q[idx_q]);
    disp_sel_d = ~(NDIG'(1) << idx_q);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      pre_q      <= '0;
      idx_q      <= '0;
      disp_num_q <= '0;
      disp_sel_q <= ~NDIG'(1);
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      pre_q      <= pre_d;
      idx_q      <= idx_d;
      disp_num_q <= disp_num_d;
      disp_sel_q <= disp_sel_d;
    end
  end

  assign bus.count    = count_q;
  assign bus.wrap     = wrap_q;
  assign bus.disp_num = disp_num_q;
  assign bus.disp_sel = disp_sel_q;

endmodule

`default_nettype wire

// File: tb/tb_bcd_scan_counter.sv
// tb_bcd_scan_counter: directed vectors, scan sequences and randomized model check.
// Rev 1.0
`default_nettype none

module tb_bcd_scan_counter;

  localparam int NDIG     = 4;
  localparam int SCAN_DIV = 4;
  localparam int MAXV     = 9999;

  logic clk;
  logic rst_n;

  bcd_scan_counter_if #(.NDIG(NDIG)) bus ();

  bcd_scan_counter #(
    .NDIG     (NDIG),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // Reference model: count held as a plain decimal integer.
  int m_count = 0;
  bit m_wrap  = 1'b0;
  int m_edges = 0;

  typedef struct {
    string       name;
    bit          ld;
    logic [15:0] lv;
    bit          tk;
    bit          u;
    logic [15:0] ec;
    bit          ew;
  } vec_t;

  vec_t vecs[$];

  function automatic int digit(input int v, input int i);
    int p = 1;
    for (int k = 0; k < i; k++) p = p * 10;
    return (v / p) % 10;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < NDIG; i++) r[4*i +: 4] = 4'(digit(v, i));
    return r;
  endfunction

  function automatic int sanitize(input logic [15:0] lv);
    int m = 0;
    int p = 1;
    for (int i = 0; i < NDIG; i++) begin
      if (lv[4*i +: 4] <= 4'd9) m = m + int'(lv[4*i +: 4]) * p;
      p = p * 10;
    end
    return m;
  endfunction

  function automatic logic [3:0] rev4(input logic [3:0] v);
    return {v[0], v[1], v[2], v[3]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic step(input bit ld, input logic [15:0] lv, input bit tk, input bit u);
    int         di;
    logic [3:0] en;
    logic [3:0] es;
    di = (m_edges / SCAN_DIV) % NDIG;
    en = rev4(4'(digit(m_count, di)));
    es = ~(4'b0001 << di);
    bus.load     = ld;
    bus.load_val = lv;
    bus.tick     = tk;
    bus.up       = u;
    @(posedge clk);
    #1;
    if (ld) begin
      m_count = sanitize(lv);
      m_wrap  = 1'b0;
    end else if (tk) begin
      if (u) begin
        m_wrap  = (m_count == MAXV);
        m_count = m_wrap ? 0 : m_count + 1;
      end else begin
        m_wrap  = (m_count == 0);
        m_count = m_wrap ? MAXV : m_count - 1;
      end
    end else begin
      m_wrap = 1'b0;
    end
    m_edges++;
    check("model_count", 32'(bus.count), 32'(to_bcd(m_count)));
    check("model_wrap", 32'(bus.wrap), 32'(m_wrap));
    check("model_disp_num", 32'(bus.disp_num), 32'(en));
    check("model_disp_sel", 32'(bus.disp_sel), 32'(es));
  endtask

  // Reset asserted together with load and tick: reset must win.
  task automatic do_reset();
    bus.load     = 1'b1;
    bus.load_val = 16'h5555;
    bus.tick     = 1'b1;
    bus.up       = 1'b1;
    rst_n        = 1'b0;
    @(posedge clk);
    #1;
    rst_n   = 1'b1;
    m_count = 0;
    m_wrap  = 1'b0;
    m_edges = 0;
    check("rst_count", 32'(bus.count), 32'h0);
    check("rst_wrap", 32'(bus.wrap), 32'h0);
    check("rst_disp_sel", 32'(bus.disp_sel), 32'b1110);
    check("rst_disp_num", 32'(bus.disp_num), 32'h0);
  endtask

  logic [3:0] sel_tab [4];
  logic [3:0] num_tab [4];

  initial begin
    rst_n        = 1'b0;
    bus.tick     = 1'b0;
    bus.up       = 1'b1;
    bus.load     = 1'b0;
    bus.load_val = '0;

    vecs.push_back('{"load_0999",   1, 16'h0999, 0, 1, 16'h0999, 0});
    vecs.push_back('{"inc_carry",   0, 16'h0000, 1, 1, 16'h1000, 0});
    vecs.push_back('{"load_9999",   1, 16'h9999, 0, 1, 16'h9999, 0});
    vecs.push_back('{"inc_ovf",     0, 16'h0000, 1, 1, 16'h0000, 1});
    vecs.push_back('{"ovf_pulse",   0, 16'h0000, 0, 1, 16'h0000, 0});
    vecs.push_back('{"load_1000",   1, 16'h1000, 0, 0, 16'h1000, 0});
    vecs.push_back('{"dec_borrow",  0, 16'h0000, 1, 0, 16'h0999, 0});
    vecs.push_back('{"load_0000",   1, 16'h0000, 0, 0, 16'h0000, 0});
    vecs.push_back('{"dec_unf",     0, 16'h0000, 1, 0, 16'h9999, 1});
    vecs.push_back('{"unf_pulse",   0, 16'h0000, 0, 0, 16'h9999, 0});
    vecs.push_back('{"load_prio",   1, 16'h3FA5, 1, 1, 16'h3005, 0});
    vecs.push_back('{"inc_plain",   0, 16'h0000, 1, 1, 16'h3006, 0});
    vecs.push_back('{"dir_change",  0, 16'h0000, 1, 0, 16'h3005, 0});
    vecs.push_back('{"tick_run",    0, 16'h0000, 1, 0, 16'h3004, 0});
    vecs.push_back('{"load_ffff",   1, 16'hFFFF, 1, 0, 16'h0000, 0});

    sel_tab = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    num_tab = '{4'b0010, 4'b1100, 4'b0100, 4'b1000};

    repeat (2) @(posedge clk);
    #1;
    do_reset();

    foreach (vecs[i]) begin
      step(vecs[i].ld, vecs[i].lv, vecs[i].tk, vecs[i].u);
      check({vecs[i].name, "_count"}, 32'(bus.count), 32'(vecs[i].ec));
      check({vecs[i].name, "_wrap"}, 32'(bus.wrap), 32'(vecs[i].ew));
    end

    // Scan through 0x1234 with a fresh frame.
    do_reset();
    step(1'b1, 16'h1234, 1'b0, 1'b1);
    for (int e = 2; e <= 16; e++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      check("scan_sel", 32'(bus.disp_sel), 32'(sel_tab[(e-1)/SCAN_DIV]));
      check("scan_num", 32'(bus.disp_num), 32'(num_tab[(e-1)/SCAN_DIV]));
    end

    // Run into decade 2, then reset mid-scan.
    for (int e = 17; e <= 26; e++) step(1'b0, 16'h0000, 1'b0, 1'b1);
    check("pre_reset_sel", 32'(bus.disp_sel), 32'b1011);
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      step(1'b0, 16'h0000, 1'b0, 1'b1);
      check("midrst_sel", 32'(bus.disp_sel), (e <= SCAN_DIV) ? 32'b1110 : 32'b1101);
    end

    // Randomized run against the integer model.
    begin
      bit          u;
      bit          ld;
      logic [15:0] lv;
      u = 1'b1;
      for (int n = 0; n < 600; n++) begin
        ld = ($urandom_range(0, 15) == 0);
        case ($urandom_range(0, 5))
          0:       lv = 16'h9998;
          1:       lv = 16'h0001;
          2:       lv = 16'h9999;
          default: lv = 16'($urandom);
        endcase
        if ($urandom_range(0, 7) == 0) u = ~u;
        step(ld, lv, ($urandom_range(0, 3) != 0), u);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
